// File: rtl/ask4_symbol_source_if.sv
// Symbol-source bus: run/mode control in, clock enables and the 1s17 symbol out.
// master = the symbol source, slave = the consumer (SRRC filter / controller).
interface ask4_symbol_source_if;
  logic               run;
  logic [1:0]         mode;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic signed [17:0] sym_out;

  modport master (input run, mode, output sam_clk_en, sym_clk_en, sym_out);
  modport slave  (output run, mode, input sam_clk_en, sym_clk_en, sym_out);
endinterface

// File: rtl/ask4_symbol_source.sv
// Sample/symbol clock-enable generator and 4-ASK symbol source (PRBS, impulse,
// constant, alternating) feeding the SRRC transmit filter.
`ifndef SYMBOL_P2
`define SYMBOL_P2 18'sd98304
`endif
`ifndef SYMBOL_P1
`define SYMBOL_P1 18'sd32768
`endif
`ifndef SYMBOL_N1
`define SYMBOL_N1 -18'sd32768
`endif
`ifndef SYMBOL_N2
`define SYMBOL_N2 -18'sd98304
`endif

module ask4_symbol_source #(
  parameter int unsigned        SAM_DIV = 4,
  parameter logic        [14:0] SEED    = 15'h0001,
  parameter logic signed [17:0] SYM_P2  = `SYMBOL_P2,
  parameter logic signed [17:0] SYM_P1  = `SYMBOL_P1,
  parameter logic signed [17:0] SYM_N1  = `SYMBOL_N1,
  parameter logic signed [17:0] SYM_N2  = `SYMBOL_N2
) (
  input  logic                       clk,
  input  logic                       reset,
  ask4_symbol_source_if.master       bus
);

  typedef enum logic [1:0] {ARMED, FIRED, DONE} imp_state_t;

  localparam logic [7:0] LAST = 8'(SAM_DIV - 1);

  logic [7:0]  clk_cnt, clk_cnt_nxt;
  logic [1:0]  sam_cnt, sam_cnt_nxt;
  logic [14:0] lfsr, lfsr_src, lfsr_adv;
  logic        fb1, fb0;
  logic        phase;
  imp_state_t  imp_state;
  logic signed [17:0] prbs_sym;

  // Enables are registered from the next-state counters so they line up with
  // the cycle in which clk_cnt == SAM_DIV-1.
  always_comb begin
    clk_cnt_nxt = (clk_cnt == LAST) ? 8'd0 : clk_cnt + 8'd1;
    sam_cnt_nxt = bus.sam_clk_en ? sam_cnt + 2'd1 : sam_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt        <= 8'd0;
      sam_cnt        <= 2'd0;
      bus.sam_clk_en <= 1'b0;
      bus.sym_clk_en <= 1'b0;
    end else begin
      clk_cnt        <= clk_cnt_nxt;
      sam_cnt        <= sam_cnt_nxt;
      bus.sam_clk_en <= (clk_cnt_nxt == LAST);
      bus.sym_clk_en <= (clk_cnt_nxt == LAST) && (sam_cnt_nxt == 2'd3);
    end
  end

  // Two Fibonacci steps per symbol; an all-zero state restarts from SEED.
  always_comb begin
    lfsr_src = (lfsr == 15'd0) ? SEED : lfsr;
    fb1      = lfsr_src[14] ^ lfsr_src[13];
    fb0      = lfsr_src[13] ^ lfsr_src[12];
    lfsr_adv = {lfsr_src[12:0], fb1, fb0};
    case ({fb1, fb0})
      2'b00:   prbs_sym = SYM_N2;
      2'b01:   prbs_sym = SYM_N1;
      2'b11:   prbs_sym = SYM_P1;
      default: prbs_sym = SYM_P2;
    endcase
  end

  // Symbol decisions happen only on sym_clk_en; run==0 freezes all symbol state.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.sym_out <= '0;
      lfsr        <= SEED;
      phase       <= 1'b0;
      imp_state   <= ARMED;
    end else if (bus.sym_clk_en) begin
      if (!bus.run) begin
        bus.sym_out <= '0;
      end else begin
        if (bus.mode != 2'b01) imp_state <= ARMED;
        if (bus.mode != 2'b11) phase     <= 1'b0;
        case (bus.mode)
          2'b00: begin
            bus.sym_out <= prbs_sym;
            lfsr        <= lfsr_adv;
          end
          2'b01: begin
            if (imp_state == ARMED) begin
              bus.sym_out <= SYM_P2;
              imp_state   <= FIRED;
            end else begin
              bus.sym_out <= '0;
              imp_state   <= DONE;
            end
          end
          2'b10:   bus.sym_out <= SYM_P1;
          default: begin
            bus.sym_out <= phase ? SYM_N2 : SYM_P2;
            phase       <= ~phase;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ask4_symbol_source.sv
// Bench for ask4_symbol_source: enable timing, PRBS against a bit-stream model,
// impulse/constant/alternating tables, run gating, mid-symbol reset, random modes.
module tb_ask4_symbol_source;

  localparam int          SD   = 4;
  localparam logic [14:0] SEED = 15'h0001;
  localparam logic signed [17:0] P2 = 18'sd98304;
  localparam logic signed [17:0] P1 = 18'sd32768;
  localparam logic signed [17:0] N1 = -18'sd32768;
  localparam logic signed [17:0] N2 = -18'sd98304;
  localparam logic signed [17:0] Z  = 18'sd0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ask4_symbol_source_if sif ();

  ask4_symbol_source #(.SAM_DIV(SD), .SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.master)
  );

  always #5 clk = ~clk;

  // Reference: PRBS as a bit stream b[n] = b[n-15]^b[n-14], seeded oldest-first.
  bit [0:2047] bits;
  int   m_pos;
  bit   m_armed;
  bit   m_phase;

  task automatic gen_bits();
    for (int i = 0; i < 15; i++) bits[i] = SEED[14-i];
    for (int i = 15; i < 2048; i++) bits[i] = bits[i-15] ^ bits[i-14];
  endtask

  task automatic model_reset();
    m_pos = 0; m_armed = 1'b1; m_phase = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] md, input logic rn, output logic signed [17:0] e);
    bit [1:0] b;
    e = Z;
    if (rn) begin
      case (md)
        2'b00: begin
          b = {bits[15 + 2*m_pos], bits[16 + 2*m_pos]};
          m_pos++;
          e = (b == 2'b00) ? N2 : (b == 2'b01) ? N1 : (b == 2'b11) ? P1 : P2;
        end
        2'b01:   begin e = m_armed ? P2 : Z; m_armed = 1'b0; end
        2'b10:   e = P1;
        default: begin e = m_phase ? N2 : P2; m_phase = ~m_phase; end
      endcase
      if (md != 2'b01) m_armed = 1'b1;
      if (md != 2'b11) m_phase = 1'b0;
    end
  endtask

  // Waits (bounded) for a symbol edge; returns sym_out just before and just after.
  task automatic next_sym(output logic signed [17:0] pre, output logic signed [17:0] post, output bit ok);
    ok = 1'b0; pre = Z; post = Z;
    for (int i = 0; i < 8*SD; i++) begin
      @(negedge clk);
      if (sif.sym_clk_en === 1'b1) begin
        pre = sif.sym_out;
        @(negedge clk);
        post = sif.sym_out;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    sif.run = 1'b1; sif.mode = 2'b00; reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (sif.sam_clk_en !== 1'b0 || sif.sym_clk_en !== 1'b0 || sif.sym_out !== Z) begin
        n_fail++;
        $display("FAIL reset_outputs sam=%b sym=%b out=%0d, want 0 0 0", sif.sam_clk_en, sif.sym_clk_en, sif.sym_out);
      end
    end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 20*SD; c++) begin
      n_tests++;
      if (sif.sam_clk_en !== ((c+1) % SD == 0) || sif.sym_clk_en !== ((c+1) % (4*SD) == 0)) begin
        n_fail++;
        $display("FAIL enable_timing cycle=%0d sam=%b sym=%b, want %b %b", c, sif.sam_clk_en, sif.sym_clk_en,
                 ((c+1) % SD == 0), ((c+1) % (4*SD) == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_prbs();
    logic signed [17:0] pre, post, e, last;
    bit ok;
    sif.run = 1'b1; sif.mode = 2'b00;
    do_reset();
    last = Z;
    for (int k = 0; k < 300; k++) begin
      next_sym(pre, post, ok);
      model_step(2'b00, 1'b1, e);
      n_tests++;
      if (!ok || pre !== last || post !== e) begin
        n_fail++;
        $display("FAIL prbs sym=%0d ok=%0b pre=%0d post=%0d, want pre=%0d post=%0d", k, ok, pre, post, last, e);
        if (!ok) return;
      end
      if (k == 0) begin
        n_tests++;
        if (post !== N2) begin
          n_fail++;
          $display("FAIL prbs_first got %0d want %0d", post, N2);
        end
      end
      last = e;
    end
  endtask

  task automatic test_impulse();
    logic [1:0] md [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    logic signed [17:0] ex [10] = '{P2, Z, Z, Z, Z, P1, P2, Z, Z, Z};
    logic signed [17:0] pre, post, last;
    bit ok;
    sif.run = 1'b1; sif.mode = 2'b01;
    do_reset();
    last = Z;
    for (int k = 0; k < 10; k++) begin
      sif.mode = md[k];
      next_sym(pre, post, ok);
      n_tests++;
      if (!ok || pre !== last || post !== ex[k]) begin
        n_fail++;
        $display("FAIL impulse step=%0d ok=%0b pre=%0d post=%0d, want pre=%0d post=%0d", k, ok, pre, post, last, ex[k]);
        if (!ok) return;
      end
      last = ex[k];
    end
  endtask

  task automatic test_alt_const();
    logic [1:0] md [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    logic signed [17:0] ex [11] = '{P2, N2, P2, N2, P2, N2, P1, P1, P1, P2, N2};
    logic signed [17:0] pre, post;
    bit ok;
    sif.run = 1'b1; sif.mode = 2'b11;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      sif.mode = md[k];
      next_sym(pre, post, ok);
      n_tests++;
      if (!ok || post !== ex[k]) begin
        n_fail++;
        $display("FAIL alt_const step=%0d ok=%0b got %0d want %0d", k, ok, post, ex[k]);
        if (!ok) return;
      end
    end
  endtask

  task automatic test_run_toggle();
    logic signed [17:0] pre, post, e, last;
    bit ok;
    logic rn;
    sif.run = 1'b1; sif.mode = 2'b00;
    do_reset();
    last = Z;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin repeat (5) @(negedge clk); sif.run = 1'b0; end
      if (k == 7) sif.run = 1'b1;
      rn = sif.run;
      next_sym(pre, post, ok);
      model_step(2'b00, rn, e);
      n_tests++;
      if (!ok || pre !== last || post !== e) begin
        n_fail++;
        $display("FAIL run_toggle sym=%0d ok=%0b pre=%0d post=%0d, want pre=%0d post=%0d", k, ok, pre, post, last, e);
        if (!ok) return;
      end
      last = e;
    end
  endtask

  task automatic test_reset_mid();
    logic signed [17:0] pre, post, e;
    bit ok;
    sif.run = 1'b1; sif.mode = 2'b11;
    do_reset();
    repeat (3) next_sym(pre, post, ok);
    repeat (7) @(negedge clk);
    sif.mode = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (sif.sam_clk_en !== 1'b0 || sif.sym_clk_en !== 1'b0 || sif.sym_out !== Z) begin
      n_fail++;
      $display("FAIL reset_mid sam=%b sym=%b out=%0d, want 0 0 0", sif.sam_clk_en, sif.sym_clk_en, sif.sym_out);
    end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 4*SD - 1; c++) begin
      n_tests++;
      if (sif.sam_clk_en !== ((c+1) % SD == 0) || sif.sym_clk_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_timing cycle=%0d sam=%b sym=%b", c, sif.sam_clk_en, sif.sym_clk_en);
      end
      @(negedge clk);
    end
    n_tests++;
    if (sif.sym_clk_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_sym cycle=%0d sym=%b want 1", 4*SD-1, sif.sym_clk_en);
    end
    @(negedge clk);
    model_step(2'b00, 1'b1, e);
    n_tests++;
    if (sif.sym_out !== e) begin
      n_fail++;
      $display("FAIL reset_mid_prbs got %0d want %0d", sif.sym_out, e);
    end
  endtask

  task automatic test_random();
    logic signed [17:0] pre, post, e, last;
    bit ok;
    logic [1:0] md;
    logic rn;
    sif.run = 1'b1; sif.mode = 2'b00;
    do_reset();
    last = Z;
    for (int k = 0; k < 200; k++) begin
      repeat ($urandom_range(0, 2*SD)) @(negedge clk);
      md = 2'($urandom_range(0, 3));
      rn = ($urandom_range(0, 3) != 0);
      sif.mode = md; sif.run = rn;
      next_sym(pre, post, ok);
      model_step(md, rn, e);
      n_tests++;
      if (!ok || pre !== last || post !== e) begin
        n_fail++;
        $display("FAIL random sym=%0d mode=%0d run=%0b pre=%0d post=%0d, want pre=%0d post=%0d",
                 k, md, rn, pre, post, last, e);
        if (!ok) return;
      end
      last = e;
    end
  endtask

  initial begin
    sif.run = 1'b0; sif.mode = 2'b00;
    gen_bits();
    model_reset();
    test_reset();
    test_prbs();
    test_impulse();
    test_alt_const();
    test_run_toggle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
